apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer_pkg.sv | 21 ++
 rtl/apb_timer_prescaler.sv | 34 +++
 rtl/apb_timer.sv | 127 ++++++++++++
 tb/tb_apb_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared register map and bit positions for the APB timer.
package apb_timer_pkg;

    // Register indices within the 8-byte window.
    localparam logic [2:0] RegCtrl     = 3'd0;
    localparam logic [2:0] RegStatus   = 3'd1;
    localparam logic [2:0] RegReloadLo = 3'd2;
    localparam logic [2:0] RegReloadHi = 3'd3;
    localparam logic [2:0] RegCountLo  = 3'd4;
    localparam logic [2:0] RegCountHi  = 3'd5;
    localparam logic [2:0] RegPrescale = 3'd6;

    // CTRL bit positions.
    localparam int unsigned CtrlEn         = 0;
    localparam int unsigned CtrlAutoreload = 1;
    localparam int unsigned CtrlIrqen      = 2;

    // STATUS bit positions.
    localparam int unsigned StatusExpired = 0;

endpackage

// File: rtl/apb_timer_prescaler.sv
// 8-bit down-counting prescaler: one-cycle tick every prescale+1 enabled cycles.
module apb_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == 8'd0);

    // Next count: explicit load, reload on tick, else decrement while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load || tick) begin
            cnt_d = prescale;
        end else if (en) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB timer: register file, 16-bit down-counter, expiry status and interrupt.
module apb_timer
    import apb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bus_if_paddr,
    input  logic       bus_if_psel,
    input  logic       bus_if_penable,
    input  logic       bus_if_pwrite,
    input  logic [7:0] bus_if_pwdata,
    output logic [7:0] bus_if_prdata,
    output logic       bus_if_pready,
    output logic       interrupt
);

    logic [2:0]  ctrl_q, ctrl_d;
    logic        expired_q, expired_d;
    logic [15:0] reload_q, reload_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  snap_q, snap_d;
    logic        irq_q;
    logic        wr_en, rd_en, load, tick;
    logic        exp_set, exp_clr;

    assign wr_en = bus_if_psel && bus_if_penable && bus_if_pwrite;
    assign rd_en = bus_if_psel && bus_if_penable && !bus_if_pwrite;

    // Only an EN 0->1 transition restarts the counters.
    assign load = wr_en && (bus_if_paddr == RegCtrl) && bus_if_pwdata[CtrlEn] && !ctrl_q[CtrlEn];

    assign bus_if_pready = bus_if_psel && bus_if_penable;
    assign interrupt     = irq_q;

    apb_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CtrlEn]),
        .load     (load),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Next state: counter/expiry first, then bus writes so a CTRL write overrides EN clear.
    always_comb begin
        ctrl_d     = ctrl_q;
        reload_d   = reload_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        snap_d     = snap_q;
        exp_set    = 1'b0;
        exp_clr    = 1'b0;

        if (load) begin
            count_d = reload_q;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                exp_set = 1'b1;
                if (ctrl_q[CtrlAutoreload]) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d[CtrlEn] = 1'b0;
                end
            end
        end

        if (wr_en) begin
            case (bus_if_paddr)
                RegCtrl:     ctrl_d          = bus_if_pwdata[2:0];
                RegStatus:   exp_clr         = bus_if_pwdata[StatusExpired];
                RegReloadLo: reload_d[7:0]   = bus_if_pwdata;
                RegReloadHi: reload_d[15:8]  = bus_if_pwdata;
                RegPrescale: prescale_d      = bus_if_pwdata;
                default:     ;
            endcase
        end

        // Set wins over a simultaneous write-1-to-clear.
        expired_d = exp_set || (expired_q && !exp_clr);

        if (rd_en && (bus_if_paddr == RegCountLo)) begin
            snap_d = count_q[15:8];
        end
    end

    // State registers; reset takes priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            expired_q  <= 1'b0;
            reload_q   <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            snap_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            expired_q  <= expired_d;
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            irq_q      <= expired_q && ctrl_q[CtrlIrqen];
        end
    end

    // Read mux; drives zero outside a read access phase.
    always_comb begin
        bus_if_prdata = '0;
        if (rd_en) begin
            case (bus_if_paddr)
                RegCtrl:     bus_if_prdata = {5'b0, ctrl_q};
                RegStatus:   bus_if_prdata = {7'b0, expired_q};
                RegReloadLo: bus_if_prdata = reload_q[7:0];
                RegReloadHi: bus_if_prdata = reload_q[15:8];
                RegCountLo:  bus_if_prdata = count_q[7:0];
                RegCountHi:  bus_if_prdata = snap_q;
                RegPrescale: bus_if_prdata = prescale_q;
                default:     bus_if_prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: stimulus queues expectations, a monitor compares.
module tb_apb_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] paddr = '0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready;
    logic       interrupt;
    logic       probe = 1'b0;

    int n_checks = 0;
    int n_bad = 0;

    // Expected {interrupt, pready, prdata} under a mask.
    typedef struct {
        string      name;
        logic [9:0] exp;
        logic [9:0] mask;
    } chk_t;

    chk_t sb[$];
    chk_t cur;
    logic [9:0] act;

    localparam logic [2:0] ACtrl = 3'd0, AStatus = 3'd1, ARelLo = 3'd2, ARelHi = 3'd3;
    localparam logic [2:0] ACntLo = 3'd4, ACntHi = 3'd5, APre = 3'd6, ARes = 3'd7;

    apb_timer dut (
        .clk            (clk),
        .rst            (rst),
        .bus_if_paddr   (paddr),
        .bus_if_psel    (psel),
        .bus_if_penable (penable),
        .bus_if_pwrite  (pwrite),
        .bus_if_pwdata  (pwdata),
        .bus_if_prdata  (prdata),
        .bus_if_pready  (pready),
        .interrupt      (interrupt)
    );

    always #5 clk = ~clk;

    // Monitor: every access phase or probe cycle consumes one expectation.
    always @(negedge clk) begin
        if ((psel && penable) || probe) begin
            act = {interrupt, pready, prdata};
            n_checks++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected-beat: got %h, none expected", act);
            end else begin
                cur = sb.pop_front();
                if ((act & cur.mask) !== (cur.exp & cur.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got irq/rdy/data=%h want %h (mask %h)",
                             cur.name, act & cur.mask, cur.exp & cur.mask, cur.mask);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        sb.push_back('{"wr-pready", 10'h100, 10'h100});
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        step(1);
        penable = 1'b1;
        step(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_gen(input logic [2:0] a, input logic [9:0] e, input logic [9:0] m,
                          input string name);
        sb.push_back('{name, e, m});
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        step(1);
        penable = 1'b1;
        step(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Read checking pready and data.
    task automatic rd(input logic [2:0] a, input logic [7:0] d, input string name);
        rd_gen(a, {2'b01, d}, 10'h1FF, name);
    endtask

    // Read also checking interrupt.
    task automatic rdi(input logic [2:0] a, input logic [7:0] d, input logic irq,
                       input string name);
        rd_gen(a, {irq, 1'b1, d}, 10'h3FF, name);
    endtask

    // Idle cycle: interrupt as given, pready and prdata must be 0.
    task automatic idle_probe(input logic irq, input string name);
        sb.push_back('{name, {irq, 9'h000}, 10'h3FF});
        probe = 1'b1;
        step(1);
        probe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] order [8];
        order = '{ACntHi, ACtrl, AStatus, ARelLo, ARelHi, ACntLo, APre, ARes};

        step(2);
        rst = 1'b0;

        // Reset state.
        idle_probe(1'b0, "reset-idle");
        for (int i = 0; i < 8; i++) rdi(i[2:0], 8'h00, 1'b0, "reset-reg");

        // Autoreload: reload 3, prescale 1 -> period 8.
        wr(ARelLo, 8'h03);
        wr(ARelHi, 8'h00);
        wr(APre, 8'h01);
        wr(ACtrl, 8'h07);                        // edge E0
        step(6);
        rdi(AStatus, 8'h00, 1'b0, "ar-before-exp");   // access after E7
        idle_probe(1'b0, "ar-irq-lag");               // after E8: expired, irq not yet
        idle_probe(1'b1, "ar-irq-rise");              // after E9
        wr(AStatus, 8'h01);                           // clear at E12
        rdi(AStatus, 8'h00, 1'b0, "ar-cleared");      // after E13
        rdi(AStatus, 8'h00, 1'b0, "ar-pre-2nd");      // after E15
        rdi(AStatus, 8'h01, 1'b1, "ar-2nd-exp");      // after E17
        step(4);
        wr(AStatus, 8'h01);                           // W1C on expiry edge E24
        rdi(AStatus, 8'h01, 1'b1, "w1c-set-wins");    // after E25
        wr(AStatus, 8'h01);                           // clear at E28
        idle_probe(1'b1, "w1c-irq-lag");              // after E28
        idle_probe(1'b0, "w1c-irq-fall");             // after E29
        rdi(AStatus, 8'h00, 1'b0, "w1c-cleared");     // after E31
        step(2);
        idle_probe(1'b1, "ar-irq-again");             // after E34
        do_reset();
        idle_probe(1'b0, "rst-irq-clear");
        rd(ACtrl, 8'h00, "rst-ctrl");
        rd(AStatus, 8'h00, "rst-status");

        // One-shot: reload 2, prescale 0.
        wr(ARelLo, 8'h02);
        wr(ARelHi, 8'h00);
        wr(APre, 8'h00);
        wr(ACtrl, 8'h05);                              // edge E0
        rdi(AStatus, 8'h00, 1'b0, "os-running");       // after E1
        rdi(AStatus, 8'h01, 1'b0, "os-expired");       // after E3
        rdi(ACtrl, 8'h04, 1'b1, "os-en-cleared");      // after E5
        rd(ACntLo, 8'h00, "os-cnt-lo");
        rd(ACntHi, 8'h00, "os-cnt-hi");
        step(5);
        rd(ACntLo, 8'h00, "os-cnt-hold");

        // Snapshot: reload 0x1234, prescale 0.
        do_reset();
        wr(ARelLo, 8'h34);
        wr(ARelHi, 8'h12);
        wr(ACtrl, 8'h01);                              // edge E0
        step(49);
        rd(ACntLo, 8'h02, "snap-lo");                  // after E50: 0x1202
        step(5);
        rd(ACntHi, 8'h12, "snap-hi-held");             // after E57: live 0x11FB
        rd(ACntLo, 8'hF9, "snap-lo-2");                // after E59: 0x11F9
        rd(ACntHi, 8'h11, "snap-hi-2");

        // Reset during a RELOAD_LO write access phase, counter running.
        sb.push_back('{"rst-wr-pready", 10'h100, 10'h100});
        psel = 1'b1; pwrite = 1'b1; paddr = ARelLo; pwdata = 8'h55; penable = 1'b0;
        step(1);
        penable = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        foreach (order[i]) rdi(order[i], 8'h00, 1'b0, "midrst-reg");

        // Reserved address, ignored bits, read-only count.
        rd(ARes, 8'h00, "res-read");
        wr(ARes, 8'hFF);
        rd(ARes, 8'h00, "res-after-wr");
        wr(ACtrl, 8'hF8);
        rd(ACtrl, 8'h00, "ctrl-unused-bits");
        wr(APre, 8'hA5);
        rd(APre, 8'hA5, "prescale-rw");
        wr(ACntLo, 8'h77);
        rd(ACntLo, 8'h00, "cnt-lo-ro");
        idle_probe(1'b0, "idle-end");

        step(1);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_checks++;
            n_bad++;
            $display("FAIL %s: got no beat, want %h", cur.name, cur.exp);
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
